// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Redirects from execute either retarget the PC directly or flush the request in flight.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [1:0]  pc_src,
    input  logic        zero,
    input  logic [31:0] br_offset,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_VALID
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        flush;
    logic [31:0] pc4;
    logic [31:0] target;
    logic [31:0] target_aligned;

    // The resolving instruction is always the one last handed to decode.
    always_comb begin
        pc4    = instr_pc + 32'd4;
        target = pc4;
        case (pc_src)
            2'b00:   target = pc4;
            2'b01:   target = zero ? pc4 + {br_offset[29:0], 2'b00} : pc4;
            2'b10:   target = {pc4[31:28], jump_index, 2'b00};
            default: target = jr_target;
        endcase
        target_aligned = {target[31:2], 2'b00};
    end

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            pend_pc      <= RESET_PC;
            flush        <= 1'b0;
            instr_valid  <= 1'b0;
            instr        <= 32'd0;
            instr_pc     <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (target[1:0] != 2'b00);
            case (state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc <= target_aligned;
                    end
                    state <= S_FETCH;
                end
                // The address must stay put until accepted, so a redirect is parked in pend_pc.
                S_FETCH: begin
                    if (redirect_valid) begin
                        pend_pc <= target_aligned;
                        flush   <= 1'b1;
                    end
                    if (imem_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect_valid) begin
                            pc    <= target_aligned;
                            flush <= 1'b0;
                            state <= S_FETCH;
                        end else if (flush) begin
                            pc    <= pend_pc;
                            flush <= 1'b0;
                            state <= S_FETCH;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= S_VALID;
                        end
                    end else if (redirect_valid) begin
                        pend_pc <= target_aligned;
                        flush   <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (redirect_valid) begin
                        pc          <= target_aligned;
                        instr_valid <= 1'b0;
                        state       <= S_FETCH;
                    end else if (instr_ready) begin
                        pc          <= pc + 32'd4;
                        instr_valid <= 1'b0;
                        state       <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
